// File: rtl/count_pkg.sv
// count_pkg: shared types, helpers and field presets for the count_wrap family.
//   btn_state_t : button auto-repeat FSM states
//   clog2max    : bit width for a timer that must hold max(a, b)
//   *_LO / *_HI : value ranges of the standard time/date fields
package count_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } btn_state_t;

   // Smallest width w (at least 1) with 2**w > max(a, b).
   function automatic int clog2max(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) <= m) begin
            w = i + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

   // Field presets
   localparam int SEC_LO  = 0;
   localparam int SEC_HI  = 59;
   localparam int MIN_LO  = 0;
   localparam int MIN_HI  = 59;
   localparam int HOUR_LO = 0;
   localparam int HOUR_HI = 23;
   localparam int DAY_LO  = 1;
   localparam int DAY_HI  = 31;
   localparam int MON_LO  = 1;
   localparam int MON_HI  = 12;
   localparam int YEAR_LO = 0;
   localparam int YEAR_HI = 99;

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: press-and-hold auto-repeat for an inc/dec button pair.
//   clk, rst_n        : clock, async active-low reset
//   en                : adjust mode enable; low forces IDLE
//   inc_btn, dec_btn  : debounced button levels
//   step_up, step_dn  : one-cycle step requests (combinational from state + buttons)
// A press steps once immediately, again after HOLD_CYC cycles of holding,
// then every REPEAT_CYC cycles. Releasing, pressing the opposite button or
// leaving adjust mode aborts the press without a step.
module btn_repeat
   import count_pkg::*;
#(
   parameter int HOLD_CYC   = 50,
   parameter int REPEAT_CYC = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic inc_btn,
   input  logic dec_btn,
   output logic step_up,
   output logic step_dn
);

   localparam int            TW        = clog2max(HOLD_CYC, REPEAT_CYC);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

   btn_state_t    state_q, state_d;
   logic          dir_up_q, dir_up_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          held_s;
   logic          opp_s;
   logic          abort_s;
   logic          step_s;
   logic          dir_s;

   // Latched button still held, or the opposite one pressed.
   assign held_s  = dir_up_q ? inc_btn : dec_btn;
   assign opp_s   = dir_up_q ? dec_btn : inc_btn;
   assign abort_s = ~held_s | opp_s;

   // State, direction and timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dir_up_q <= 1'b0;
         timer_q  <= {TW{1'b0}};
      end else begin
         state_q  <= state_d;
         dir_up_q <= dir_up_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state and timer logic.
   always_comb begin
      state_d  = state_q;
      dir_up_d = dir_up_q;
      timer_d  = timer_q;
      if (!en) begin
         state_d = IDLE;
         timer_d = {TW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (inc_btn ^ dec_btn) begin
                  state_d  = HOLD;
                  dir_up_d = inc_btn;
                  timer_d  = {TW{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end
            HOLD: begin
               if (abort_s) begin
                  state_d = IDLE;
                  timer_d = {TW{1'b0}};
               end else if (timer_q == HOLD_LAST) begin
                  state_d = REPEAT;
                  timer_d = {TW{1'b0}};
               end else begin
                  timer_d = timer_q + TW'(1'b1);
               end
            end
            REPEAT: begin
               if (abort_s) begin
                  state_d = IDLE;
                  timer_d = {TW{1'b0}};
               end else if (timer_q == REP_LAST) begin
                  timer_d = {TW{1'b0}};
               end else begin
                  timer_d = timer_q + TW'(1'b1);
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = {TW{1'b0}};
            end
         endcase
      end
   end

   // Step outputs; in IDLE the direction comes straight from the button.
   always_comb begin
      step_s = 1'b0;
      dir_s  = dir_up_q;
      if (!en) begin
         step_s = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               step_s = inc_btn ^ dec_btn;
               dir_s  = inc_btn;
            end
            HOLD:    step_s = ~abort_s & (timer_q == HOLD_LAST);
            REPEAT:  step_s = ~abort_s & (timer_q == REP_LAST);
            default: step_s = 1'b0;
         endcase
      end
      step_up = step_s & dir_s;
      step_dn = step_s & ~dir_s;
   end

endmodule

// File: rtl/count_wrap.sv
// count_wrap: wrap-around time/date field counter with set-mode adjust.
//   clk, rst_n        : clock, async active-low reset
//   tick              : carry-in from the lower field (run mode only)
//   set_mode          : 1 = adjust with buttons, 0 = run
//   inc_btn, dec_btn  : debounced adjust buttons
//   lim_max           : runtime upper limit, used when DYN_MAX=1
//   cnt               : current value in [MIN_VAL, limit]
//   carry             : one-cycle pulse on run-mode wrap
module count_wrap
   import count_pkg::*;
#(
   parameter int WIDTH      = 5,
   parameter int MIN_VAL    = 0,
   parameter int MAX_VAL    = 23,
   parameter int DYN_MAX    = 0,
   parameter int HOLD_CYC   = 50,
   parameter int REPEAT_CYC = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             set_mode,
   input  logic             inc_btn,
   input  logic             dec_btn,
   input  logic [WIDTH-1:0] lim_max,
   output logic [WIDTH-1:0] cnt,
   output logic             carry
);

   localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] lim_s;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             step_up_s;
   logic             step_dn_s;

   assign lim_s = (DYN_MAX != 0) ? lim_max : MAX_W;

   btn_repeat #(
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (set_mode),
      .inc_btn (inc_btn),
      .dec_btn (dec_btn),
      .step_up (step_up_s),
      .step_dn (step_dn_s)
   );

   // Value and carry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= MIN_W;
         carry_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
      end
   end

   // Clamp beats adjust steps, which beat run-mode ticks.
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = 1'b0;
      if (cnt_q > lim_s) begin
         // Limit dropped below the value (e.g. shorter month): pull it in.
         cnt_d = lim_s;
      end else if (set_mode) begin
         if (step_up_s) begin
            cnt_d = (cnt_q == lim_s) ? MIN_W : cnt_q + WIDTH'(1'b1);
         end else if (step_dn_s) begin
            cnt_d = (cnt_q == MIN_W) ? lim_s : cnt_q - WIDTH'(1'b1);
         end else begin
            cnt_d = cnt_q;
         end
      end else if (tick) begin
         if (cnt_q == lim_s) begin
            cnt_d   = MIN_W;
            carry_d = 1'b1;
         end else begin
            cnt_d = cnt_q + WIDTH'(1'b1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign cnt   = cnt_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_count_wrap.sv
// Bench for count_wrap: several field instances checked every cycle against a
// press-age based reference model, plus hand-computed literal expectations.
module tb_count_wrap;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Hour field, static limit
   logic a_tick, a_set, a_inc, a_dec;
   logic [4:0] a_cnt;
   logic a_carry;
   // Day field, runtime limit
   logic b_tick, b_set, b_inc, b_dec;
   logic [4:0] b_lim, b_cnt;
   logic b_carry;
   // Month field
   logic c_tick, c_set, c_inc, c_dec;
   logic [3:0] c_cnt;
   logic c_carry;
   // SEC -> MIN -> HOUR chain
   logic s_tick, ch_set, s_dec, m_dec, h_dec;
   logic [5:0] s_cnt, m_cnt;
   logic [4:0] h_cnt;
   logic s_carry, m_carry, h_carry;

   count_wrap #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .DYN_MAX(0), .HOLD_CYC(4), .REPEAT_CYC(2)) u_a (
      .clk(clk), .rst_n(rst_n), .tick(a_tick), .set_mode(a_set), .inc_btn(a_inc), .dec_btn(a_dec),
      .lim_max(5'd0), .cnt(a_cnt), .carry(a_carry));
   count_wrap #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .DYN_MAX(1), .HOLD_CYC(4), .REPEAT_CYC(2)) u_b (
      .clk(clk), .rst_n(rst_n), .tick(b_tick), .set_mode(b_set), .inc_btn(b_inc), .dec_btn(b_dec),
      .lim_max(b_lim), .cnt(b_cnt), .carry(b_carry));
   count_wrap #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .DYN_MAX(0), .HOLD_CYC(3), .REPEAT_CYC(1)) u_c (
      .clk(clk), .rst_n(rst_n), .tick(c_tick), .set_mode(c_set), .inc_btn(c_inc), .dec_btn(c_dec),
      .lim_max(4'd0), .cnt(c_cnt), .carry(c_carry));
   count_wrap #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .DYN_MAX(0), .HOLD_CYC(4), .REPEAT_CYC(2)) u_s (
      .clk(clk), .rst_n(rst_n), .tick(s_tick), .set_mode(ch_set), .inc_btn(1'b0), .dec_btn(s_dec),
      .lim_max(6'd0), .cnt(s_cnt), .carry(s_carry));
   count_wrap #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .DYN_MAX(0), .HOLD_CYC(4), .REPEAT_CYC(2)) u_m (
      .clk(clk), .rst_n(rst_n), .tick(s_carry), .set_mode(ch_set), .inc_btn(1'b0), .dec_btn(m_dec),
      .lim_max(6'd0), .cnt(m_cnt), .carry(m_carry));
   count_wrap #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .DYN_MAX(0), .HOLD_CYC(4), .REPEAT_CYC(2)) u_h (
      .clk(clk), .rst_n(rst_n), .tick(m_carry), .set_mode(ch_set), .inc_btn(1'b0), .dec_btn(h_dec),
      .lim_max(5'd0), .cnt(h_cnt), .carry(h_carry));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a press is tracked by its age k (cycles since it began);
   // it steps at age 0, at age h, and every r cycles after that.
   typedef struct {
      int cnt;
      bit carry;
      bit active;
      bit up;
      int k;
   } mdl_t;

   function automatic mdl_t mreset(input int lo);
      mdl_t n;
      n.cnt = lo; n.carry = 1'b0; n.active = 1'b0; n.up = 1'b0; n.k = 0;
      return n;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit tick, input bit set, input bit inc,
                                  input bit dec, input int lo, input int hi, input int h, input int r);
      mdl_t n;
      bit su, sd, held, opp;
      n = m; n.carry = 1'b0; su = 1'b0; sd = 1'b0;
      if (!set) begin
         n.active = 1'b0;
      end else if (m.active) begin
         held = m.up ? inc : dec;
         opp  = m.up ? dec : inc;
         if (!held || opp) begin
            n.active = 1'b0;
         end else begin
            n.k = m.k + 1;
            if (n.k == h || (n.k > h && ((n.k - h) % r) == 0)) begin
               su = m.up; sd = !m.up;
            end
         end
      end else if (inc != dec) begin
         n.active = 1'b1; n.up = inc; n.k = 0; su = inc; sd = dec;
      end
      if (m.cnt > hi) n.cnt = hi;
      else if (set) begin
         if (su) n.cnt = (m.cnt == hi) ? lo : m.cnt + 1;
         else if (sd) n.cnt = (m.cnt == lo) ? hi : m.cnt - 1;
      end else if (tick) begin
         if (m.cnt == hi) begin n.cnt = lo; n.carry = 1'b1; end
         else n.cnt = m.cnt + 1;
      end
      return n;
   endfunction

   mdl_t ma, mb, mc, ms, mm, mh;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= mreset(0); mb <= mreset(1); mc <= mreset(1);
         ms <= mreset(0); mm <= mreset(0); mh <= mreset(0);
      end else begin
         ma <= mstep(ma, a_tick, a_set, a_inc, a_dec, 0, 23, 4, 2);
         mb <= mstep(mb, b_tick, b_set, b_inc, b_dec, 1, int'(b_lim), 4, 2);
         mc <= mstep(mc, c_tick, c_set, c_inc, c_dec, 1, 12, 3, 1);
         ms <= mstep(ms, s_tick, ch_set, 1'b0, s_dec, 0, 59, 4, 2);
         mm <= mstep(mm, ms.carry, ch_set, 1'b0, m_dec, 0, 59, 4, 2);
         mh <= mstep(mh, mm.carry, ch_set, 1'b0, h_dec, 0, 23, 4, 2);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("a_cnt", int'(a_cnt), ma.cnt);  chk("a_carry", int'(a_carry), int'(ma.carry));
      chk("b_cnt", int'(b_cnt), mb.cnt);  chk("b_carry", int'(b_carry), int'(mb.carry));
      chk("c_cnt", int'(c_cnt), mc.cnt);  chk("c_carry", int'(c_carry), int'(mc.carry));
      chk("s_cnt", int'(s_cnt), ms.cnt);  chk("s_carry", int'(s_carry), int'(ms.carry));
      chk("m_cnt", int'(m_cnt), mm.cnt);  chk("m_carry", int'(m_carry), int'(mm.carry));
      chk("h_cnt", int'(h_cnt), mh.cnt);  chk("h_carry", int'(h_carry), int'(mh.carry));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int sc, mc_n, hc;

   initial begin
      rst_n = 1'b0;
      a_tick = 1'b0; a_set = 1'b0; a_inc = 1'b0; a_dec = 1'b0;
      b_tick = 1'b0; b_set = 1'b0; b_inc = 1'b0; b_dec = 1'b0; b_lim = 5'd31;
      c_tick = 1'b0; c_set = 1'b0; c_inc = 1'b0; c_dec = 1'b0;
      s_tick = 1'b0; ch_set = 1'b0; s_dec = 1'b0; m_dec = 1'b0; h_dec = 1'b0;
      cyc(2);
      chk("rst_a_cnt", int'(a_cnt), 0); chk("rst_a_carry", int'(a_carry), 0);
      chk("rst_b_cnt", int'(b_cnt), 1); chk("rst_c_cnt", int'(c_cnt), 1);
      rst_n = 1'b1;

      // Hour wrap
      a_tick = 1'b1; cyc(23); a_tick = 1'b0;
      chk("hr_pre", int'(a_cnt), 23);
      a_tick = 1'b1; cyc(1); a_tick = 1'b0;
      chk("hr_wrap", int'(a_cnt), 0); chk("hr_carry", int'(a_carry), 1);
      cyc(1);
      chk("hr_carry_drop", int'(a_carry), 0);

      // Day field with runtime limit and clamp
      b_tick = 1'b1; cyc(29);
      chk("day_30", int'(b_cnt), 30);
      cyc(1);
      chk("day_31", int'(b_cnt), 31); chk("day_31_carry", int'(b_carry), 0);
      cyc(1); b_tick = 1'b0;
      chk("day_wrap", int'(b_cnt), 1); chk("day_carry", int'(b_carry), 1);
      b_tick = 1'b1; cyc(30); b_tick = 1'b0;
      chk("day_31b", int'(b_cnt), 31);
      b_lim = 5'd28; b_tick = 1'b1; cyc(1); b_tick = 1'b0;
      chk("day_clamp", int'(b_cnt), 28); chk("day_clamp_carry", int'(b_carry), 0);
      cyc(1);
      chk("day_clamp_hold", int'(b_cnt), 28);
      b_lim = 5'd31;

      // Set-mode hold/repeat: steps at 0,4,6,8,10 from 5
      a_tick = 1'b1; cyc(5); a_tick = 1'b0;
      chk("hold_start", int'(a_cnt), 5);
      a_set = 1'b1; a_inc = 1'b1; a_tick = 1'b1; cyc(12); a_inc = 1'b0; a_tick = 1'b0;
      chk("hold_cnt", int'(a_cnt), 10); chk("hold_carry", int'(a_carry), 0);
      cyc(1);

      // Drop set mode mid-repeat
      a_inc = 1'b1; cyc(8);
      chk("rep_cnt", int'(a_cnt), 13);
      a_set = 1'b0; cyc(3);
      chk("abort_hold", int'(a_cnt), 13);
      a_inc = 1'b0; a_tick = 1'b1; cyc(1); a_tick = 1'b0;
      chk("abort_tick", int'(a_cnt), 14);

      // Reset mid-repeat, button still held after release
      a_set = 1'b1; a_inc = 1'b1; cyc(7);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", int'(a_cnt), 0);
      @(negedge clk); rst_n = 1'b1;
      cyc(1);
      chk("rst_fresh", int'(a_cnt), 1);
      a_inc = 1'b0; a_set = 1'b0; cyc(1);

      // Month decrement wrap, then both buttons
      c_set = 1'b1; c_dec = 1'b1; cyc(1); c_dec = 1'b0;
      chk("mon_dec_wrap", int'(c_cnt), 12); chk("mon_dec_carry", int'(c_carry), 0);
      cyc(1);
      c_inc = 1'b1; c_dec = 1'b1; cyc(5); c_inc = 1'b0; c_dec = 1'b0;
      chk("mon_both", int'(c_cnt), 12);
      c_set = 1'b0;

      // Chain: preload 23:59:59 by one decrement each, then one tick
      ch_set = 1'b1; s_dec = 1'b1; m_dec = 1'b1; h_dec = 1'b1; cyc(1);
      s_dec = 1'b0; m_dec = 1'b0; h_dec = 1'b0;
      chk("ch_s59", int'(s_cnt), 59); chk("ch_m59", int'(m_cnt), 59); chk("ch_h23", int'(h_cnt), 23);
      cyc(1); ch_set = 1'b0;
      s_tick = 1'b1; cyc(1); s_tick = 1'b0;
      sc = 0; mc_n = 0; hc = 0;
      for (int i = 0; i < 6; i++) begin
         sc += int'(s_carry); mc_n += int'(m_carry); hc += int'(h_carry);
         cyc(1);
      end
      chk("ch_s0", int'(s_cnt), 0); chk("ch_m0", int'(m_cnt), 0); chk("ch_h0", int'(h_cnt), 0);
      chk("ch_s_pulses", sc, 1); chk("ch_m_pulses", mc_n, 1); chk("ch_h_pulses", hc, 1);

      // Randomized phase, checked by the model every cycle
      repeat (3000) begin
         a_tick = ($urandom_range(0, 3) == 32'd0);
         b_tick = ($urandom_range(0, 3) == 32'd0);
         c_tick = ($urandom_range(0, 3) == 32'd0);
         s_tick = ($urandom_range(0, 1) == 32'd0);
         if ($urandom_range(0, 39) == 32'd0) a_set = ~a_set;
         if ($urandom_range(0, 39) == 32'd0) b_set = ~b_set;
         if ($urandom_range(0, 39) == 32'd0) c_set = ~c_set;
         if ($urandom_range(0, 9) == 32'd0) a_inc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 32'd0) a_dec = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 32'd0) b_inc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 32'd0) b_dec = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 32'd0) c_inc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 32'd0) c_dec = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 32'd0) b_lim = 5'($urandom_range(28, 31));
         cyc(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_wrap.md
Name: count_wrap

Overview:
- Parametrised wrap-around time/date field counter; next generation of the hour counter.
- One instance per field: seconds, minutes, hours, day, month, year-in-century.
- Chained by carry: carry-out of one field drives tick of the next.
- Adds over the previous generation:
  - configurable range, including fields that start at 1;
  - runtime upper limit (days-in-month);
  - increment and decrement adjust with hold-to-auto-repeat in set mode;
  - fully defined carry output.

Parameters:
- WIDTH, 5: counter width in bits.
- MIN_VAL, 0: lowest count value (1 for day/month).
- MAX_VAL, 23: static upper limit, used when DYN_MAX=0.
- DYN_MAX, 0: 1 selects lim_max as the upper limit.
- HOLD_CYC, 50: cycles a button must stay held after the first step before auto-repeat starts. Must be ≥1.
- REPEAT_CYC, 10: cycles between auto-repeat steps. Must be ≥1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- tick, input, 1: count enable / carry-in from the lower field. Single-cycle pulse.
- set_mode, input, 1: 1 = adjust mode, 0 = run mode.
- inc_btn, input, 1: increment request. Level, already synchronised and debounced.
- dec_btn, input, 1: decrement request. Level, already synchronised and debounced.
- lim_max, input, WIDTH: runtime upper limit. Used only when DYN_MAX=1.
- cnt, output, WIDTH: current value.
- carry, output, 1: one-cycle wrap pulse to the next field.

Behaviour:
- Effective limit:
  - LIM = lim_max when DYN_MAX=1, otherwise MAX_VAL.
  - Integrator guarantees MIN_VAL ≤ LIM.
- Reset (asynchronous assert, synchronous release):
  - cnt=MIN_VAL, carry=0;
  - button FSM=IDLE, repeat timer=0.
- Per-cycle priority, highest first: reset, clamp, set-mode step, run-mode tick.
- Clamp:
  - If cnt > LIM (e.g. lim_max falls from 31 to 28), cnt becomes LIM on the next edge.
  - carry=0 on that cycle; any tick or step on that cycle is dropped.
- Run mode (set_mode=0):
  - tick=1 with cnt==LIM: cnt becomes MIN_VAL and carry=1 on the next cycle only.
  - tick=1 with cnt<LIM: cnt becomes cnt+1, carry=0.
  - tick=0: cnt holds, carry=0.
  - Latency: tick at edge N is visible on cnt/carry after edge N+1.
  - Button FSM forced to IDLE.
- Set mode (set_mode=1):
  - tick is ignored and carry is held 0.
  - Only the button FSM moves cnt.
  - Step up: cnt==LIM wraps to MIN_VAL, otherwise cnt+1.
  - Step down: cnt==MIN_VAL wraps to LIM, otherwise cnt-1.
  - Steps in set mode never generate carry; no ripple into other fields.
- Button FSM states: IDLE, HOLD, REPEAT. Direction is latched on leaving IDLE.
  - IDLE: exactly one of inc_btn/dec_btn high → one step now (cnt updates next edge), timer cleared, go to HOLD.
  - IDLE: both high or neither high → stay in IDLE, no step.
  - HOLD: latched button still high → timer counts up.
  - HOLD: timer reaches HOLD_CYC-1 → one step, timer cleared, go to REPEAT.
  - REPEAT: one step each time the timer reaches REPEAT_CYC-1, then timer clears.
  - Any state: latched button released, opposite button asserted, or set_mode dropped → IDLE, timer cleared, no step that cycle.
  - Opposite button requires a pass through IDLE (release first) before it takes effect.
  - Timer is sized to count to max(HOLD_CYC, REPEAT_CYC).
- Reset mid-hold or mid-repeat: FSM returns to IDLE immediately. A button still held after release causes one fresh first step.
- All arithmetic is WIDTH-bit unsigned. No value outside [MIN_VAL, LIM] is reachable, except transiently after an lim_max drop, for at most one cycle before the clamp.

Decomposition:
- Package count_pkg holds:
  - btn_state_t enum (IDLE, HOLD, REPEAT);
  - timer-width function clog2max(a, b);
  - field presets (SEC: 0..59, MIN: 0..59, HOUR: 0..23, DAY: 1..31, MON: 1..12, YEAR: 0..99).
- Sub-module btn_repeat:
  - inputs: clk, rst_n, en(=set_mode), inc_btn, dec_btn;
  - outputs: step_up and step_dn, one-cycle pulses;
  - contains the FSM and the timer.
- count_wrap contains the value register, wrap/clamp logic and carry.

Test Plan:
- Reset wrap, hours (MIN 0, MAX 23): rst_n low → cnt=0, carry=0. Preload to 23 by ticks, then tick once → cnt=0, carry=1 for exactly one cycle. Then tick=0 → carry=0.
- Day field, DYN_MAX=1, MIN 1, lim_max=31: cnt=30, tick, tick → 31 then 1 with carry. Set cnt=31, change lim_max to 28 → cnt=28 next cycle, carry=0.
- Set mode, HOLD_CYC=4, REPEAT_CYC=2: inc_btn held 12 cycles from cnt=5 → steps on cycles 0, 4, 6, 8, 10 → final cnt=10. Ticks applied meanwhile ignored, carry stays 0.
- Decrement wrap, month field: cnt=1, one dec_btn press → cnt=12, no carry. Both buttons pressed together → cnt unchanged.
- Mode/reset abort: inc held into REPEAT, then set_mode dropped → stepping stops, FSM in IDLE. Next tick counts normally. Reset asserted mid-REPEAT → cnt=MIN_VAL immediately.
- Chain SEC→MIN→HOUR: start at 23:59:59, one tick into SEC → all fields 0, each carry pulses exactly once.
